// File: rtl/edge_detect_multi.sv
// N-channel edge detector: optional input synchronizer, glitch filter and a 4-state Moore FSM
// per channel, with mode-gated ticks feeding sticky pending flags and an OR-reduced irq.
module edge_detect_multi #(
   parameter int unsigned N             = 4,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned FILTER_CYCLES = 3
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   level,
   input  logic [2*N-1:0] mode,
   input  logic [N-1:0]   clr,
   output logic [N-1:0]   filt_level,
   output logic [N-1:0]   rise,
   output logic [N-1:0]   fall,
   output logic [N-1:0]   tick,
   output logic [N-1:0]   pending,
   output logic           irq
);

   localparam int unsigned   CW      = $clog2(FILTER_CYCLES + 1);
   localparam logic [CW-1:0] CntLast = CW'(FILTER_CYCLES - 1);

   typedef enum logic [1:0] {StZero, StRise, StOne, StFall} state_e;

   logic [N-1:0] synced;
   logic [N-1:0] pending_q, pending_d;

   for (genvar i = 0; i < N; i++) begin : g_ch
      logic [CW-1:0] cnt_q, cnt_d;
      logic          filt_q, filt_d;
      state_e        state_q, state_d;

      if (SYNC_STAGES == 0) begin : g_nosync
         assign synced[i] = level[i];
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;
         logic [SYNC_STAGES:0]   chain;

         assign chain     = {sync_q, level[i]};
         assign synced[i] = sync_q[SYNC_STAGES-1];

         always_ff @(posedge clk) begin
            if (reset) begin
               sync_q <= '0;
            end else begin
               sync_q <= chain[SYNC_STAGES-1:0];
            end
         end
      end

      // Level must disagree for FILTER_CYCLES consecutive edges before it is accepted.
      always_comb begin
         cnt_d  = '0;
         filt_d = filt_q;
         if (synced[i] != filt_q) begin
            if (cnt_q == CntLast) begin
               filt_d = ~filt_q;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      end

      always_comb begin
         state_d = state_q;
         unique case (state_q)
            StZero:  state_d = filt_q ? StRise : StZero;
            StRise:  state_d = filt_q ? StOne  : StFall;
            StOne:   state_d = filt_q ? StOne  : StFall;
            StFall:  state_d = filt_q ? StRise : StZero;
            default: state_d = StZero;
         endcase
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            cnt_q   <= '0;
            filt_q  <= 1'b0;
            state_q <= StZero;
         end else begin
            cnt_q   <= cnt_d;
            filt_q  <= filt_d;
            state_q <= state_d;
         end
      end

      assign filt_level[i] = filt_q;
      assign rise[i]       = (state_q == StRise) & mode[2*i];
      assign fall[i]       = (state_q == StFall) & mode[2*i+1];
   end

   assign tick = rise | fall;

   // A tick arriving together with a clear keeps the flag set.
   assign pending_d = (pending_q & ~clr) | tick;

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign pending = pending_q;
   assign irq     = |pending_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Self-checking bench for edge_detect_multi: directed scenarios plus random stimulus, all
// compared every cycle against a delayed-sample reference model of the filtered level.
module tb_edge_detect_multi;

   localparam int unsigned N    = 4;
   localparam int unsigned SYNC = 2;
   localparam int unsigned FILT = 3;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   level;
   logic [2*N-1:0] mode;
   logic [N-1:0]   clr;
   logic [N-1:0]   filt_level, rise, fall, tick, pending;
   logic           irq;

   logic [0:0] level2;
   logic [1:0] mode2;
   logic [0:0] clr2;
   logic [0:0] filt2, rise2, fall2, tick2, pend2;
   logic       irq2;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   logic [N-1:0] m_filt, m_fd1, m_fd2, m_pend;
   int           m_run [N];
   logic [15:0]  m_hist [N];

   always #5 clk = ~clk;

   edge_detect_multi #(.N(N), .SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT)) dut (
      .clk        (clk),
      .reset      (reset),
      .level      (level),
      .mode       (mode),
      .clr        (clr),
      .filt_level (filt_level),
      .rise       (rise),
      .fall       (fall),
      .tick       (tick),
      .pending    (pending),
      .irq        (irq)
   );

   edge_detect_multi #(.N(1), .SYNC_STAGES(0), .FILTER_CYCLES(1)) dut2 (
      .clk        (clk),
      .reset      (reset),
      .level      (level2),
      .mode       (mode2),
      .clr        (clr2),
      .filt_level (filt2),
      .rise       (rise2),
      .fall       (fall2),
      .tick       (tick2),
      .pending    (pend2),
      .irq        (irq2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // A tick is the filtered level, one edge late, differing from its value one edge earlier.
   function automatic logic [N-1:0] exp_rise();
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = m_fd1[i] & ~m_fd2[i] & mode[2*i];
      return r;
   endfunction

   function automatic logic [N-1:0] exp_fall();
      logic [N-1:0] f;
      for (int i = 0; i < N; i++) f[i] = ~m_fd1[i] & m_fd2[i] & mode[2*i+1];
      return f;
   endfunction

   task automatic model_edge();
      logic [N-1:0] tk;
      logic         syn;
      if (reset) begin
         m_filt = '0; m_fd1 = '0; m_fd2 = '0; m_pend = '0;
         for (int i = 0; i < N; i++) begin
            m_run[i]  = 0;
            m_hist[i] = '0;
         end
      end else begin
         tk     = exp_rise() | exp_fall();
         m_pend = (m_pend & ~clr) | tk;
         m_fd2  = m_fd1;
         m_fd1  = m_filt;
         for (int i = 0; i < N; i++) begin
            syn = (SYNC == 0) ? level[i] : m_hist[i][SYNC-1];
            if (syn == m_filt[i]) begin
               m_run[i] = 0;
            end else begin
               m_run[i]++;
               if (m_run[i] == FILT) begin
                  m_filt[i] = ~m_filt[i];
                  m_run[i]  = 0;
               end
            end
            m_hist[i] = {m_hist[i][14:0], level[i]};
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("filt_level", 32'(filt_level), 32'(m_filt));
      chk("rise",       32'(rise),       32'(exp_rise()));
      chk("fall",       32'(fall),       32'(exp_fall()));
      chk("tick",       32'(tick),       32'(exp_rise() | exp_fall()));
      chk("pending",    32'(pending),    32'(m_pend));
      chk("irq",        32'(irq),        32'(|m_pend));
   endtask

   initial begin
      int  nr, nf, nt;
      logic seen;

      reset = 1'b1; level = '0; mode = '0; clr = '0;
      level2 = '0; mode2 = 2'b11; clr2 = '0;
      step(); step();
      reset = 1'b0;
      step();
      chk("reset_pending", 32'(pending), 32'h0);
      chk("reset_irq",     32'(irq),     32'h0);

      // 1: rise latency on ch0
      mode = 8'b00_00_00_01;
      level[0] = 1'b1;
      for (int e = 0; e < 8; e++) begin
         step();
         chk("t1_rise0", 32'(rise[0]), 32'(e == 5));
         if (e >= 6) begin
            chk("t1_pend0", 32'(pending[0]), 32'h1);
            chk("t1_irq",   32'(irq),        32'h1);
         end
      end

      // 2: short pulse filtered out, long pulse gives one rise and one fall on ch1
      mode[3:2] = 2'b11;
      level[1] = 1'b1; step(); step();
      level[1] = 1'b0;
      nt = 0;
      for (int e = 0; e < 10; e++) begin
         step();
         chk("t2_filt1", 32'(filt_level[1]), 32'h0);
         nt += int'(tick[1]);
      end
      chk("t2_short_ticks", 32'(nt), 32'h0);
      level[1] = 1'b1;
      for (int e = 0; e < 5; e++) step();
      level[1] = 1'b0;
      nr = 0; nf = 0;
      for (int e = 0; e < 20; e++) begin
         step();
         nr += int'(rise[1]);
         nf += int'(fall[1]);
      end
      chk("t2_long_rises", 32'(nr), 32'h1);
      chk("t2_long_falls", 32'(nf), 32'h1);

      // 3: ch2 fall-only, then mode off
      mode[5:4] = 2'b10;
      level[2] = 1'b1;
      nr = 0;
      for (int e = 0; e < 8; e++) begin step(); nr += int'(rise[2]); end
      level[2] = 1'b0;
      nf = 0;
      for (int e = 0; e < 10; e++) begin step(); nr += int'(rise[2]); nf += int'(fall[2]); end
      chk("t3_rises", 32'(nr), 32'h0);
      chk("t3_falls", 32'(nf), 32'h1);
      mode[5:4] = 2'b00;
      level[2] = 1'b1;
      nt = 0;
      for (int e = 0; e < 8; e++) begin step(); nt += int'(tick[2]); end
      chk("t3_off_filt_hi", 32'(filt_level[2]), 32'h1);
      level[2] = 1'b0;
      for (int e = 0; e < 8; e++) begin step(); nt += int'(tick[2]); end
      chk("t3_off_filt_lo", 32'(filt_level[2]), 32'h0);
      chk("t3_off_ticks",   32'(nt), 32'h0);

      // 4: clear coinciding with a tick keeps pending
      mode[7:6] = 2'b11;
      level[3] = 1'b1;
      for (int e = 0; e < 8; e++) step();
      chk("t4_pend3_set", 32'(pending[3]), 32'h1);
      clr = 4'b0111; step(); clr = '0;
      level[3] = 1'b0;
      seen = 1'b0;
      for (int e = 0; e < 12 && !seen; e++) begin
         step();
         seen = tick[3];
      end
      chk("t4_tick_seen", 32'(seen), 32'h1);
      clr[3] = 1'b1; step();
      chk("t4_set_wins", 32'(pending[3]), 32'h1);
      clr = 4'hF; step();
      chk("t4_cleared", 32'(pending), 32'h0);
      chk("t4_irq_lo",  32'(irq),     32'h0);
      clr = '0;

      // 5: reset mid-filter on ch0 and during RISE on ch2
      mode = 8'h55;
      level = '0;
      for (int e = 0; e < 8; e++) step();
      level[2] = 1'b1;
      for (int e = 0; e < 6; e++) step();
      chk("t5_in_rise2", 32'(rise[2]), 32'h1);
      level[0] = 1'b1;
      for (int e = 0; e < 4; e++) step();
      reset = 1'b1; step();
      chk("t5_rst_filt", 32'(filt_level), 32'h0);
      chk("t5_rst_tick", 32'(tick), 32'h0);
      chk("t5_rst_pend", 32'(pending), 32'h0);
      chk("t5_rst_irq",  32'(irq), 32'h0);
      reset = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         step();
         chk("t5_rise0", 32'(rise[0]), 32'(k == 6));
         chk("t5_rise2", 32'(rise[2]), 32'(k == 6));
      end

      // 6: unfiltered, unsynchronized channel toggling every cycle
      for (int k = 0; k < 14; k++) begin
         level2 = 1'(k & 1);
         step();
         if (k >= 2) begin
            chk("t6_rise", 32'(rise2), 32'((k & 1) == 0));
            chk("t6_fall", 32'(fall2), 32'((k & 1) == 1));
            chk("t6_tick", 32'(tick2), 32'h1);
         end
      end
      level2 = '0;

      // Random phase
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 5) == 0) level[i] = ~level[i];
            clr[i] = ($urandom_range(0, 7) == 0);
         end
         if ($urandom_range(0, 19) == 0) mode = 8'($urandom);
         reset = ($urandom_range(0, 99) == 0);
         step();
      end
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
